// File: rtl/ped_pkg.sv
// ============================================================================
// ped_pkg : shared state encoding and widths for the pedestrian request block
// Rev 1.0
// ============================================================================
`default_nettype none

package ped_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      SERVE = 2'd2
   } ped_state_t;

   localparam int unsigned DEF_CLK_HZ = 30000000;
   localparam int unsigned MS_PER_S   = 1000;
   localparam int unsigned TICK_DIV   = DEF_CLK_HZ / MS_PER_S;

   localparam int unsigned DB_W  = 8;
   localparam int unsigned SEC_W = 8;
   localparam int unsigned MS_W  = 10;

   function automatic int unsigned tick_div_of(input int unsigned clk_hz);
      return clk_hz / MS_PER_S;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ped_request_tick_gen.sv
// ============================================================================
// tick_gen : 1 kHz one-cycle strobe derived from the system clock
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen
   import ped_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEF_CLK_HZ
)(
   input  logic clk30M,
   input  logic Reset,
   output logic tick
);

   localparam int unsigned DIV = tick_div_of(CLK_HZ);
   localparam int unsigned W   = (DIV > 2) ? $clog2(DIV) : 1;

   logic [W-1:0] r_cnt;
   logic         r_tick;

   always_ff @(posedge clk30M or posedge Reset) begin
      if (Reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == W'(DIV - 1)) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/ped_request.sv
// ============================================================================
// ped_request : debounced pedestrian key to registered crossing request
// Optional request timeout enabled by defining PED_REQ_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ped_request
   import ped_pkg::*;
#(
   parameter int unsigned CLK_HZ      = TICK_DIV * MS_PER_S,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned TIMEOUT_S   = 120
)(
   input  logic clk30M,
   input  logic Reset,
   input  logic btn_n,
   input  logic grant,
   output logic req,
   output logic press_pulse,
   output logic btn_clean,
   output logic timeout
);

   if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_debounce
      $error("DEBOUNCE_MS out of range 1..255");
   end
   if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_bad_timeout
      $error("TIMEOUT_S out of range 1..255");
   end

   logic            w_tick;
   logic            r_sync1;
   logic            r_sync2;
   logic            w_level;
   logic [DB_W-1:0] r_db_cnt;
   logic [DB_W-1:0] w_db_next;
   logic            r_clean;
   logic            r_clean_q;
   logic            r_press;
   ped_state_t      r_state;
   logic            r_req;

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk30M (clk30M),
      .Reset  (Reset),
      .tick   (w_tick)
   );

   // Synchronizer resets to 1 so a released key looks idle from the start.
   assign w_level   = ~r_sync2;
   assign w_db_next = r_db_cnt + 1'b1;

   always_ff @(posedge clk30M or posedge Reset) begin
      if (Reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_db_cnt  <= '0;
         r_clean   <= 1'b0;
         r_clean_q <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync1   <= btn_n;
         r_sync2   <= r_sync1;
         r_clean_q <= r_clean;
         r_press   <= r_clean & ~r_clean_q;
         if (w_tick) begin
            if (w_level != r_clean) begin
               if (w_db_next == DB_W'(DEBOUNCE_MS)) begin
                  r_clean  <= w_level;
                  r_db_cnt <= '0;
               end else begin
                  r_db_cnt <= w_db_next;
               end
            end else begin
               r_db_cnt <= '0;
            end
         end
      end
   end

`ifdef PED_REQ_TIMEOUT_EN
   logic [MS_W-1:0]  r_ms;
   logic [SEC_W-1:0] r_sec;
   logic             r_timeout;
`endif

   always_ff @(posedge clk30M or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_req     <= 1'b0;
`ifdef PED_REQ_TIMEOUT_EN
         r_ms      <= '0;
         r_sec     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
`ifdef PED_REQ_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (grant) begin
                  r_state <= SERVE;
               end else if (r_press) begin
                  r_state <= WAIT;
                  r_req   <= 1'b1;
`ifdef PED_REQ_TIMEOUT_EN
                  r_ms    <= '0;
                  r_sec   <= '0;
`endif
               end
            end
            WAIT: begin
               // grant is checked first so it wins over an expiring timeout
               if (grant) begin
                  r_state <= SERVE;
                  r_req   <= 1'b0;
               end
`ifdef PED_REQ_TIMEOUT_EN
               else if (w_tick) begin
                  if (r_ms == MS_W'(MS_PER_S - 1)) begin
                     r_ms <= '0;
                     if (r_sec == SEC_W'(TIMEOUT_S - 1)) begin
                        r_state   <= IDLE;
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                     end else begin
                        r_sec <= r_sec + 1'b1;
                     end
                  end else begin
                     r_ms <= r_ms + 1'b1;
                  end
               end
`endif
            end
            SERVE: begin
               if (!grant) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PED_REQ_TIMEOUT_EN
   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   assign req         = r_req;
   assign press_pulse = r_press;
   assign btn_clean   = r_clean;

endmodule

`default_nettype wire

// File: doc/ped_request.md
PED_REQUEST -- requirements
Module: ped_request

Interface
REQ-001 Parameter CLK_HZ, default 30000000: input clock frequency in Hz, used to derive the 1 kHz tick.
REQ-002 Parameter DEBOUNCE_MS, default 20: consecutive stable 1 ms ticks needed to accept a button level change; legal range 1..255.
REQ-003 Parameter TIMEOUT_S, default 120: seconds before an unserved request is cancelled; legal range 1..255; used only with PED_REQ_TIMEOUT_EN.
REQ-004 Port clk30M, input, 1: the single system clock; all logic on its rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-high reset.
REQ-006 Port btn_n, input, 1: raw pedestrian key, active-low, asynchronous to clk30M, bouncing.
REQ-007 Port grant, input, 1: level from the light controller, 1 while the pedestrian-crossing phase is active.
REQ-008 Port req, output, 1: registered pending pedestrian request to the light controller.
REQ-009 Port press_pulse, output, 1: one-cycle strobe on each accepted (debounced) press.
REQ-010 Port btn_clean, output, 1: debounced button level, active-high (1 = pressed).
REQ-011 Port timeout, output, 1: one-cycle strobe when a request is cancelled by timeout; tied 0 without PED_REQ_TIMEOUT_EN.

Function
REQ-012 The block shall pass btn_n through a 2-flop synchronizer before any other use.
REQ-013 The block shall generate a 1 kHz tick: a one-cycle strobe every CLK_HZ/1000 clocks (30000 at the default clock frequency).
REQ-014 On each tick, the debounce counter shall:
- increment while the synchronized level differs from btn_clean;
- clear on any tick where the levels match.
REQ-015 When the debounce counter reaches DEBOUNCE_MS, btn_clean shall take the synchronized level and the counter shall clear, all in the same cycle.
REQ-016 press_pulse shall assert for exactly one cycle, in the cycle after btn_clean goes 0 to 1; a release shall never pulse.
REQ-017 The FSM shall have exactly three states: IDLE (req=0), WAIT (req=1) and SERVE (req=0).
REQ-018 IDLE transitions:
- grant=1 goes to SERVE; this takes priority when it coincides with press_pulse.
- otherwise, press_pulse goes to WAIT.
REQ-019 WAIT transitions: grant=1 goes to SERVE; further presses have no effect.
REQ-020 SERVE transitions: grant=0 goes to IDLE; presses while in SERVE are discarded.
REQ-021 req shall be registered and valid in the cycle after the FSM enters WAIT.
REQ-022 Worst-case press-to-req latency shall be 2 sync cycles + (DEBOUNCE_MS+1) ticks + 2 cycles.
REQ-023 Bounce shorter than DEBOUNCE_MS ticks shall produce no press_pulse.

Reset
REQ-024 While Reset=1, the block shall hold: FSM in IDLE; synchronizer flops at 1 (released key); btn_clean=0; req=0; press_pulse=0; timeout=0; all counters at 0.
REQ-025 Reset asserted mid-WAIT shall drop req asynchronously, without waiting for a clock edge.
REQ-026 After reset release, a key already held down shall be accepted as a press once debounce completes.

Configuration
REQ-027 With PED_REQ_TIMEOUT_EN defined:
- a seconds counter shall advance on every 1000th tick while in WAIT;
- on reaching TIMEOUT_S, the FSM shall go to IDLE and timeout shall pulse for one cycle;
- the seconds counter shall clear on every WAIT entry;
- if grant=1 arrives in the same cycle as the timeout, grant shall win (go to SERVE, no timeout pulse).
REQ-028 Without PED_REQ_TIMEOUT_EN, no seconds counter shall be synthesized, WAIT shall persist until grant, and timeout shall be constant 0.

Structure
REQ-029 A shared package ped_pkg shall hold the FSM state encoding (IDLE/WAIT/SERVE), the TICK_DIV constant (CLK_HZ/1000) and the counter width constants.
REQ-030 The 1 kHz prescaler shall be a sub-module named tick_gen (ports: clk30M, Reset, tick); all other logic shall live in ped_request.

Verification
(Bench uses CLK_HZ=30000, giving a 30-cycle tick, and DEBOUNCE_MS=4.)
REQ-031 Clean press: btn_n held low for 10 ticks -> exactly one press_pulse, and req=1 within 2+5 ticks+2 cycles.
REQ-032 Bounce: btn_n toggling every 1 tick for 20 ticks, then high -> no press_pulse, req stays 0.
REQ-033 Grant: in WAIT, grant=1 -> req=0 next cycle; a press during grant -> still 0; grant=0 then a new press -> req=1.
REQ-034 Coincidence: in IDLE, press_pulse in the same cycle as grant rising -> FSM in SERVE, req never asserts.
REQ-035 Reset mid-WAIT: Reset=1 between clock edges -> req=0 immediately; after release with key still held -> req=1 after debounce.
REQ-036 With PED_REQ_TIMEOUT_EN and TIMEOUT_S=2: press, no grant -> timeout pulses once after 2000 ticks, and req returns to 0.
